// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and the hex-to-segment lookup used by the
// multiplexed 7-segment scan controller.
//   SEG_A..SEG_DP  bit positions inside an {dp,g,f,e,d,c,b,a} segment byte
//   seg7_hex2seg   nibble -> active-high segment byte (dp bit cleared)
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    function automatic logic [7:0] seg7_hex2seg(input logic [3:0] hex);
        logic [7:0] seg;
        case (hex)
            4'h0:    seg = 8'h3F;
            4'h1:    seg = 8'h06;
            4'h2:    seg = 8'h5B;
            4'h3:    seg = 8'h4F;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'h6D;
            4'h6:    seg = 8'h7D;
            4'h7:    seg = 8'h07;
            4'h8:    seg = 8'h7F;
            4'h9:    seg = 8'h6F;
            4'hA:    seg = 8'h77;
            4'hB:    seg = 8'h7C;
            4'hC:    seg = 8'h39;
            4'hD:    seg = 8'h5E;
            4'hE:    seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble + decimal point -> active-high
// segment byte {dp,g,f,e,d,c,b,a}.
//   nibble_i  hex digit to show
//   dp_i      decimal point enable
//   seg_o     active-high segment pattern
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o         = seg7_hex2seg(nibble_i);
        seg_o[SEG_DP] = dp_i;
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment display controller for NUM_DIGITS
// hex digits with per-digit decimal point and blanking, PWM brightness and
// frame-synchronous (tear-free) update of the displayed data.
//
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking (digits
// above the highest non-zero displayed nibble stay dark; digit 0 always
// shows unless blanked).
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-high reset
//   cs        write strobe: captures all i_* into the shadow registers
//   i_data    hex nibbles, digit k at [4k+3:4k], digit 0 rightmost
//   i_dp      decimal point per digit
//   i_blank   force digit dark
//   i_bright  PWM duty = i_bright / 2**PWM_W
//   o_seg     {dp,g,f,e,d,c,b,a}, registered, polarity per ACTIVE_LOW
//   o_sel     one-hot digit select, registered, polarity per ACTIVE_LOW
//   o_frame   one-clk pulse after the scan wraps back to digit 0
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV_W = 15,
    parameter int PWM_W      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic [PWM_W-1:0]        i_bright,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_sel,
    output logic                    o_frame
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_DIV_W-1:0] PRESC_MAX = '1;
    localparam bit                    POL_LOW   = (ACTIVE_LOW != 0);
    localparam logic [7:0]            SEG_OFF   = POL_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF   = POL_LOW ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

    logic [SCAN_DIV_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    frame_q, frame_d;

    logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [PWM_W-1:0]        sh_bright_q, sh_bright_d;

    logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;
    logic [PWM_W-1:0]        disp_bright_q, disp_bright_d;

    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic [7:0]              dec_seg;
    logic [PWM_W-1:0]        phase;
    logic                    lzb_show;
    logic                    lit;

    // Scan timing, shadow capture and frame-synchronous display load.
    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        wrap    = tick && (idx_q == LAST_IDX);
        presc_d = presc_q + SCAN_DIV_W'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        frame_d = wrap;

        sh_data_d   = sh_data_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        sh_bright_d = sh_bright_q;
        if (cs) begin
            sh_data_d   = i_data;
            sh_dp_d     = i_dp;
            sh_blank_d  = i_blank;
            sh_bright_d = i_bright;
        end

        // The display takes the shadow as it stood before this edge, so a
        // write landing on the wrap tick waits for the following frame.
        disp_data_d   = disp_data_q;
        disp_dp_d     = disp_dp_q;
        disp_blank_d  = disp_blank_q;
        disp_bright_d = disp_bright_q;
        if (wrap) begin
            disp_data_d   = sh_data_q;
            disp_dp_d     = sh_dp_q;
            disp_blank_d  = sh_blank_q;
            disp_bright_d = sh_bright_q;
        end
    end

    assign cur_nibble = disp_data_q[4*idx_q +: 4];
    assign cur_dp     = disp_dp_q[idx_q];
    assign phase      = presc_q[SCAN_DIV_W-1 -: PWM_W];

    seg7_hex_decode u_dec (
        .nibble_i (cur_nibble),
        .dp_i     (cur_dp),
        .seg_o    (dec_seg)
    );

`ifdef SEG7_LZB_EN
    logic [IDX_W-1:0] lz_top;

    always_comb begin
        lz_top = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (disp_data_q[4*k +: 4] != 4'h0) begin
                lz_top = IDX_W'(k);
            end
        end
    end

    assign lzb_show = (idx_q <= lz_top);
`else
    assign lzb_show = 1'b1;
`endif

    // Slot clock 0 is kept dark so the previous digit's segments never
    // bleed into the next digit while the select lines swap.
    assign lit = (presc_q != '0) && (phase < disp_bright_q) &&
                 !disp_blank_q[idx_q] && lzb_show;

    always_comb begin
        seg_d = lit ? dec_seg : 8'h00;
        sel_d = lit ? (SEL_ONE << idx_q) : '0;
        if (POL_LOW) begin
            seg_d = ~seg_d;
            sel_d = ~sel_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            idx_q         <= '0;
            frame_q       <= 1'b0;
            sh_data_q     <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            sh_bright_q   <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            disp_blank_q  <= '0;
            disp_bright_q <= '0;
            seg_q         <= SEG_OFF;
            sel_q         <= SEL_OFF;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            frame_q       <= frame_d;
            sh_data_q     <= sh_data_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            sh_bright_q   <= sh_bright_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            disp_blank_q  <= disp_blank_d;
            disp_bright_q <= disp_bright_d;
            seg_q         <= seg_d;
            sel_q         <= sel_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_sel   = sel_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: an 8-digit and a 6-digit instance share the
// same stimulus; a cycle-count based reference model predicts every output.
module tb_seg7_scan_ctrl;

    localparam int SDW  = 4;
    localparam int PW   = 2;
    localparam int SLOT = 1 << SDW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs  = 1'b0;
    logic [31:0] data   = '0;
    logic [7:0]  dp     = '0;
    logic [7:0]  blank  = '0;
    logic [1:0]  bright = '0;

    logic [7:0]  seg8, sel8, seg6;
    logic [5:0]  sel6;
    logic        frame8, frame6;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV_W(SDW), .PWM_W(PW), .ACTIVE_LOW(1)) dut8 (
        .clk(clk), .rst(rst), .cs(cs), .i_data(data), .i_dp(dp), .i_blank(blank),
        .i_bright(bright), .o_seg(seg8), .o_sel(sel8), .o_frame(frame8)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(6), .SCAN_DIV_W(SDW), .PWM_W(PW), .ACTIVE_LOW(1)) dut6 (
        .clk(clk), .rst(rst), .cs(cs), .i_data(data[23:0]), .i_dp(dp[5:0]), .i_blank(blank[5:0]),
        .i_bright(bright), .o_seg(seg6), .o_sel(sel6), .o_frame(frame6)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic [1:0]  bright;
    } dset_t;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int    nd [2] = '{8, 6};
    dset_t m_sh;
    dset_t m_disp [2];
    int    m_cnt;
    logic [7:0] e_seg [2];
    logic [7:0] e_sel [2];
    logic       e_frame [2];
    int    last_k, last_p;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic lzb_show(input logic [31:0] d, input int k, input int n);
`ifdef SEG7_LZB_EN
        int top = 0;
        for (int j = 1; j < n; j++) if (d[4*j +: 4] != 4'h0) top = j;
        return k <= top;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_cnt     = 0;
        m_sh      = '0;
        m_disp[0] = '0;
        m_disp[1] = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            dset_t ds = m_disp[i];
            int p = m_cnt % SLOT;
            int k = (m_cnt / SLOT) % nd[i];
            logic [3:0] nib = ds.data[4*k +: 4];
            logic en = (p != 0) && ((p >> (SDW - PW)) < int'(ds.bright)) &&
                       !ds.blank[k] && lzb_show(ds.data, k, nd[i]);
            e_seg[i]   = en ? ~{ds.dp[k], seg_tab[nib]} : 8'hFF;
            e_sel[i]   = en ? ~(8'd1 << k) : 8'hFF;
            e_frame[i] = (p == SLOT - 1) && (k == nd[i] - 1);
            if (i == 0) begin
                last_p = p;
                last_k = k;
            end
            if (e_frame[i]) m_disp[i] = m_sh;
        end
        if (cs) m_sh = '{data, dp, blank, bright};
        m_cnt++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("seg8", seg8, e_seg[0]);
        chk("sel8", sel8, e_sel[0]);
        chk("frame8", frame8, e_frame[0]);
        chk("seg6", seg6, e_seg[1]);
        chk("sel6", {2'b11, sel6}, e_sel[1]);
        chk("frame6", frame6, e_frame[1]);
    endtask

    // Advance until the outputs reflect digit k at slot clock p (8-digit scan).
    task automatic goto_out(input int k, input int p);
        int budget = 0;
        do begin
            tick();
            budget++;
        end while (!(last_k == k && last_p == p) && budget < 600);
        if (!(last_k == k && last_p == p)) begin
            n_chk++;
            $display("FAIL goto_timeout: reached digit %0d clk %0d wanted %0d/%0d", last_k, last_p, k, p);
        end
    endtask

    task automatic write(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b, input logic [1:0] br);
        data = d; dp = p; blank = b; bright = br;
        cs = 1'b1;
        tick();
        cs = 1'b0;
    endtask

    task automatic settle();
        goto_out(7, SLOT - 1);
        goto_out(0, 0);
    endtask

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic [1:0]  bright;
        int          digit;
        int          p;
        logic [7:0]  eseg;
        logic [7:0]  esel;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int cnt;
        int q8 [$];
        int q6 [$];

        tbl[0]  = '{32'h81234567, 8'h00, 8'h00, 2'd3, 0,  2, 8'hF8, 8'hFE};
        tbl[1]  = '{32'h81234567, 8'h00, 8'h00, 2'd3, 7,  2, 8'h80, 8'h7F};
        tbl[2]  = '{32'h81234567, 8'h00, 8'h00, 2'd3, 3,  5, 8'h99, 8'hF7};
        tbl[3]  = '{32'h81234567, 8'h01, 8'h00, 2'd3, 0,  2, 8'h78, 8'hFE};
        tbl[4]  = '{32'h81234567, 8'h00, 8'h02, 2'd3, 1,  2, 8'hFF, 8'hFF};
        tbl[5]  = '{32'h81234567, 8'h00, 8'h00, 2'd0, 2,  5, 8'hFF, 8'hFF};
        tbl[6]  = '{32'h81234567, 8'h00, 8'h00, 2'd2, 5,  6, 8'hA4, 8'hDF};
        tbl[7]  = '{32'h81234567, 8'h00, 8'h00, 2'd2, 5,  9, 8'hFF, 8'hFF};
        tbl[8]  = '{32'h81234567, 8'h00, 8'h00, 2'd3, 4,  0, 8'hFF, 8'hFF};
        tbl[9]  = '{32'h89ABCDEF, 8'h00, 8'h00, 2'd3, 2,  2, 8'hA1, 8'hFB};
        tbl[10] = '{32'h89ABCDEF, 8'h00, 8'h00, 2'd3, 6, 11, 8'h90, 8'hBF};
        tbl[11] = '{32'h89ABCDEF, 8'h00, 8'h00, 2'd3, 6, 12, 8'hFF, 8'hFF};
        tbl[12] = '{32'h80000000, 8'h08, 8'h00, 2'd3, 3,  1, 8'h40, 8'hF7};
        tbl[13] = '{32'h8000000A, 8'h00, 8'h00, 2'd1, 0,  3, 8'h88, 8'hFE};

        // Reset held: everything dark.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg8", seg8, 8'hFF);
        chk("rst_sel8", sel8, 8'hFF);
        chk("rst_frame8", frame8, 1'b0);
        chk("rst_sel6", {2'b11, sel6}, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (140) tick();

        // Table-driven digit/slot checks.
        for (int i = 0; i < 14; i++) begin
            write(tbl[i].data, tbl[i].dp, tbl[i].blank, tbl[i].bright);
            settle();
            goto_out(tbl[i].digit, tbl[i].p);
            chk($sformatf("tbl%0d_seg", i), seg8, tbl[i].eseg);
            chk($sformatf("tbl%0d_sel", i), sel8, tbl[i].esel);
        end

        // Mid-frame write: old data until the frame boundary.
        write(32'h81234567, 8'h00, 8'h00, 2'd3);
        settle();
        goto_out(3, 4);
        write(32'hFFFFFFFF, 8'h00, 8'h00, 2'd3);
        goto_out(7, 2);
        chk("midframe_old_d7", seg8, 8'h80);
        goto_out(0, 2);
        chk("midframe_new_d0", seg8, 8'h8E);

        // bright=2: 7 selected clocks in a slot.
        write(32'h81234567, 8'h00, 8'h00, 2'd2);
        settle();
        goto_out(3, SLOT - 1);
        cnt = 0;
        repeat (SLOT) begin
            tick();
            if (sel8 != 8'hFF) cnt++;
        end
        chk("bright2_sel_clks", cnt, 7);

        // bright=0: nothing selected for a whole frame.
        write(32'h81234567, 8'h00, 8'h00, 2'd0);
        settle();
        cnt = 0;
        repeat (8 * SLOT) begin
            tick();
            if (sel8 != 8'hFF) cnt++;
        end
        chk("bright0_sel_clks", cnt, 0);

        // Frame periods for 8 and 6 digits.
        write(32'h81234567, 8'h00, 8'h00, 2'd3);
        for (int t = 0; t < 400; t++) begin
            tick();
            if (frame8) q8.push_back(t);
            if (frame6) q6.push_back(t);
        end
        chk("frames8_seen", q8.size() >= 2, 1'b1);
        chk("frames6_seen", q6.size() >= 2, 1'b1);
        if (q8.size() >= 2) chk("frame8_period", q8[1] - q8[0], 8 * SLOT);
        if (q6.size() >= 2) chk("frame6_period", q6[1] - q6[0], 6 * SLOT);

`ifdef SEG7_LZB_EN
        write(32'h000000A0, 8'h00, 8'h00, 2'd3);
        settle();
        goto_out(0, 2);
        chk("lzb_d0_seg", seg8, 8'hC0);
        goto_out(1, 2);
        chk("lzb_d1_seg", seg8, 8'h88);
        chk("lzb_d1_sel", sel8, 8'hFD);
        goto_out(2, 2);
        chk("lzb_d2_sel", sel8, 8'hFF);
        goto_out(7, 2);
        chk("lzb_d7_sel", sel8, 8'hFF);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            data   = $urandom;
            dp     = 8'($urandom);
            blank  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            bright = 2'($urandom_range(0, 3));
            cs     = ($urandom_range(0, 5) == 0);
            tick();
        end
        cs = 1'b0;

        // Asynchronous reset mid-scan.
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_seg8", seg8, 8'hFF);
        chk("midrst_sel8", sel8, 8'hFF);
        chk("midrst_frame8", frame8, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        write(32'h81234567, 8'h00, 8'h00, 2'd3);
        settle();
        goto_out(0, 2);
        chk("restart_d0_seg", seg8, 8'hF8);
        chk("restart_d0_sel", sel8, 8'hFE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
